// File: rtl/debounce_defs.vh
// rtl/debounce_defs.vh - shared state encodings for the debounce FSM
`ifndef DEBOUNCE_DEFS_VH
`define DEBOUNCE_DEFS_VH

localparam logic [1:0] ENC_LOW_STABLE  = 2'd0;
localparam logic [1:0] ENC_HIGH_PEND   = 2'd1;
localparam logic [1:0] ENC_HIGH_STABLE = 2'd2;
localparam logic [1:0] ENC_LOW_PEND    = 2'd3;

`endif

// File: rtl/debounce_edge.sv
// rtl/debounce_edge.sv - debouncer with registered level and rise/fall pulses
module debounce_edge #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic in_sync,
  output logic level,
  output logic rise,
  output logic fall
);

  `include "debounce_defs.vh"

  typedef enum logic [1:0] {
    LOW_STABLE  = ENC_LOW_STABLE,
    HIGH_PEND   = ENC_HIGH_PEND,
    HIGH_STABLE = ENC_HIGH_STABLE,
    LOW_PEND    = ENC_LOW_PEND
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             level_n, rise_n, fall_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOW_STABLE;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      level <= level_n;
      rise  <= rise_n;
      fall  <= fall_n;
    end
  end

  // The edge that samples the new value for the STABLE_CYCLES-th time commits it,
  // so a pending count of STABLE_CYCLES-1 plus one more agreeing sample is enough.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    level_n = level;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state)
      LOW_STABLE: begin
        if (in_sync) begin
          state_n = HIGH_PEND;
          cnt_n   = CNT_ONE;
        end else begin
          cnt_n = '0;
        end
      end
      HIGH_PEND: begin
        if (!in_sync) begin
          state_n = LOW_STABLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = HIGH_STABLE;
          cnt_n   = '0;
          level_n = 1'b1;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      HIGH_STABLE: begin
        if (!in_sync) begin
          state_n = LOW_PEND;
          cnt_n   = CNT_ONE;
        end else begin
          cnt_n = '0;
        end
      end
      LOW_PEND: begin
        if (in_sync) begin
          state_n = HIGH_STABLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = LOW_STABLE;
          cnt_n   = '0;
          level_n = 1'b0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = LOW_STABLE;
        cnt_n   = '0;
        level_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_debounce_edge.sv
// tb/tb_debounce_edge.sv - directed vector bench for debounce_edge
`timescale 1ns/100ps
module tb_debounce_edge;

  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_sync = 1'b0;
  logic level, rise, fall;

  int checks = 0;
  int errors = 0;

  debounce_edge #(.STABLE_CYCLES(STABLE), .CNT_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .in_sync(in_sync),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  always #1 clk = ~clk;

  typedef struct {
    logic  r;
    logic  i;
    logic  l;
    logic  ru;
    logic  fa;
    string name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic i, input logic l, input logic ru,
                     input logic fa, input string name);
    vec_t v;
    v.r = r; v.i = i; v.l = l; v.ru = ru; v.fa = fa; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic add_n(input int n, input logic i, input logic l, input string name);
    for (int k = 0; k < n; k++) add(1'b0, i, l, 1'b0, 1'b0, name);
  endtask

  // Drive, clock once, then compare half a cycle after the edge.
  task automatic step(input logic r, input logic i, input logic el, input logic er,
                      input logic ef, input string name);
    rst = r;
    in_sync = i;
    @(posedge clk);
    #0.5;
    checks++;
    if (level !== el || rise !== er || fall !== ef) begin
      errors++;
      $display("FAIL %s: level/rise/fall got %b%b%b expected %b%b%b @%0t",
               name, level, rise, fall, el, er, ef, $time);
    end
  endtask

  logic prev_pulse = 1'b0;
  always begin
    @(posedge clk);
    #0.5;
    if (rise && fall) begin
      errors++;
      $display("FAIL pulse_exclusive: rise=%b fall=%b expected not both @%0t", rise, fall, $time);
    end
    if (prev_pulse && (rise || fall)) begin
      errors++;
      $display("FAIL pulse_consecutive: rise=%b fall=%b expected 00 after pulse @%0t",
               rise, fall, $time);
    end
    if (dut.cnt > 16'(STABLE - 1)) begin
      errors++;
      $display("FAIL cnt_bound: cnt=%0d expected <= %0d @%0t", dut.cnt, STABLE - 1, $time);
    end
    prev_pulse = rise | fall;
  end

  initial begin
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "reset_in1");
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset_in0");
    add_n(3, 1'b1, 1'b0, "press_pend");
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "press_rise");
    add_n(6, 1'b1, 1'b1, "press_hold");
    add_n(3, 1'b0, 1'b1, "release_pend");
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "release_fall");
    add_n(2, 1'b0, 1'b0, "release_hold");
    add_n(1, 1'b1, 1'b0, "glitch_hi");
    add_n(3, 1'b0, 1'b0, "glitch_after");
    add_n(3, 1'b1, 1'b0, "bounce_run1");
    add_n(1, 1'b0, 1'b0, "bounce_gap");
    add_n(3, 1'b1, 1'b0, "bounce_run2");
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "bounce_rise");
    add_n(1, 1'b1, 1'b1, "bounce_hold");
    add_n(1, 1'b0, 1'b1, "glitch_lo");
    add_n(3, 1'b1, 1'b1, "glitch_lo_after");
    add_n(3, 1'b0, 1'b1, "short_release");
    add_n(2, 1'b1, 1'b1, "short_release_after");

    @(negedge clk);
    for (int n = 0; n < vecs.size(); n++)
      step(vecs[n].r, vecs[n].i, vecs[n].l, vecs[n].ru, vecs[n].fa, vecs[n].name);

    // Reset while high: level drops silently, then a held high input rises again.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rst_in_high");
    for (int n = 0; n < STABLE - 1; n++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "post_rst_pend");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "post_rst_rise");

    // Reset mid-pending discards the partial count.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rst_settle");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "midpend_1");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "midpend_2");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "midpend_rst");
    for (int n = 0; n < STABLE - 1; n++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "midpend_restart");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "midpend_rise");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "midpend_hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_edge.md
DEBOUNCE_EDGE -- requirements
Module: debounce_edge

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, giving the consecutive cycles of constant in_sync needed to accept a new level (legal range 2..65535).
REQ-002 SHALL have parameter CNT_W, default 16, giving the counter width; SHALL satisfy 2^CNT_W > STABLE_CYCLES.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_sync  input  1  already-synchronised, possibly bouncing level from the synchroniser.
REQ-006 SHALL have port level  output  1  debounced level, registered.
REQ-007 SHALL have port rise  output  1  one-cycle pulse when level goes 0->1, registered.
REQ-008 SHALL have port fall  output  1  one-cycle pulse when level goes 1->0, registered.

Function
REQ-009 SHALL implement a four-state FSM: LOW_STABLE, HIGH_PEND, HIGH_STABLE, LOW_PEND.
REQ-010 In LOW_STABLE with in_sync=1 at an edge, SHALL move to HIGH_PEND with cnt=1; with in_sync=0, SHALL stay and hold cnt=0.
REQ-011 In HIGH_PEND with in_sync=0, SHALL return to LOW_STABLE with cnt=0, and no output SHALL change.
REQ-012 In HIGH_PEND with in_sync=1 and cnt<STABLE_CYCLES-1, SHALL increment cnt.
REQ-013 In HIGH_PEND with in_sync=1 and cnt=STABLE_CYCLES-1, SHALL move to HIGH_STABLE, set level=1, assert rise for exactly that cycle, and clear cnt.
REQ-014 HIGH_STABLE, LOW_PEND and fall SHALL mirror REQ-010..REQ-013 with the polarities swapped.
REQ-015 Latency: level SHALL change at the STABLE_CYCLES-th rising edge at which in_sync holds the new value; input that holds the new value for fewer than STABLE_CYCLES consecutive edges SHALL produce no output change.
REQ-016 rise and fall SHALL never be asserted in the same cycle, and neither SHALL be asserted on two consecutive cycles.
REQ-017 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-018 Outputs SHALL be driven only from registers; there SHALL be no combinational path from in_sync to any output.

Reset
REQ-019 While rst=1 at a rising edge, SHALL set state=LOW_STABLE, cnt=0, level=0, rise=0 and fall=0, regardless of in_sync.
REQ-020 rst SHALL take priority over every FSM transition; an assertion mid-pending SHALL discard the pending count with no pulse.
REQ-021 After rst deasserts with in_sync=1, SHALL follow the normal HIGH_PEND path, with rise after STABLE_CYCLES edges.

Structure
REQ-022 State encodings (2-bit, LOW_STABLE=0, HIGH_PEND=1, HIGH_STABLE=2, LOW_PEND=3) SHALL be defined as localparams in the shared header debounce_defs.vh.
REQ-023 SHALL be a single module with no sub-module; the counter and FSM SHALL be inline.

Verification (STABLE_CYCLES=4, 2 ns clock)
REQ-024 Clean press: in_sync 0->1 held for 10 cycles -> level=1 and rise=1 for one cycle at the 4th edge sampling 1; fall=0 throughout.
REQ-025 Bounce: in_sync high for 3 cycles, low for 1, then high for 5 -> only one rise, at the 4th edge of the final high run; level=0 before that.
REQ-026 Release: from HIGH_STABLE, in_sync=0 held for 6 cycles -> level=0 and fall=1 for one cycle at the 4th edge sampling 0.
REQ-027 Glitch: from LOW_STABLE, a 1-cycle high pulse -> level, rise and fall all stay 0.
REQ-028 Reset mid-pending: in_sync=1 for 2 cycles, then rst=1 for 1 cycle with in_sync still 1 -> all outputs 0 after the reset edge; rise at the 4th post-reset edge.
REQ-029 Throughout all scenarios, an assertion SHALL check REQ-016 and REQ-017 on every cycle.
